// File: rtl/dijkstra_pkg.sv
// Shared types and default sizing for the SmartCart shortest-path engine.
package dijkstra_pkg;

  localparam int DEF_N_NODES    = 64;
  localparam int DEF_MAX_CHILD  = 6;
  localparam int DEF_COORD_W    = 16;
  localparam int DEF_COST_W     = 16;
  localparam int DEF_PATH_DEPTH = 64;

  typedef struct packed {
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
  } coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SCAN,
    ST_RELAX,
    ST_TRACE,
    ST_FIN
  } state_t;

  // All-ones distance marks an unreachable node.
  function automatic logic [DEF_COST_W-1:0] inf_cost();
    return '1;
  endfunction

endpackage

// File: rtl/dijkstra_node_table.sv
// Node record RAM: one write port from the host loader, one registered read
// port giving coordinates and child slots of the addressed node.
module dijkstra_node_table
  import dijkstra_pkg::*;
#(
  parameter int N_NODES   = DEF_N_NODES,
  parameter int MAX_CHILD = DEF_MAX_CHILD,
  parameter int COST_W    = DEF_COST_W,
  parameter int ID_W      = $clog2(DEF_N_NODES)
) (
  input  logic                              clk,
  input  logic                              wr_en,
  input  logic [ID_W-1:0]                   wr_id,
  input  coord_t                            wr_coord,
  input  logic [MAX_CHILD-1:0]              wr_child_valid,
  input  logic [MAX_CHILD-1:0][ID_W-1:0]    wr_child_id,
  input  logic [MAX_CHILD-1:0][COST_W-1:0]  wr_child_dist,
  input  logic [ID_W-1:0]                   rd_id,
  output coord_t                            rd_coord,
  output logic [MAX_CHILD-1:0]              rd_child_valid,
  output logic [MAX_CHILD-1:0][ID_W-1:0]    rd_child_id,
  output logic [MAX_CHILD-1:0][COST_W-1:0]  rd_child_dist
);

  coord_t               coord_mem [N_NODES];
  logic [MAX_CHILD-1:0] valid_mem [N_NODES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      coord_mem[wr_id] <= wr_coord;
      valid_mem[wr_id] <= wr_child_valid;
    end
    rd_coord       <= coord_mem[rd_id];
    rd_child_valid <= valid_mem[rd_id];
  end

  // One narrow RAM per child slot keeps each array a simple inferable shape.
  for (genvar gi = 0; gi < MAX_CHILD; gi++) begin : g_slot
    logic [ID_W-1:0]   id_mem   [N_NODES];
    logic [COST_W-1:0] dist_mem [N_NODES];
    logic [ID_W-1:0]   id_q;
    logic [COST_W-1:0] dist_q;

    always_ff @(posedge clk) begin
      if (wr_en) begin
        id_mem[wr_id]   <= wr_child_id[gi];
        dist_mem[wr_id] <= wr_child_dist[gi];
      end
      id_q   <= id_mem[rd_id];
      dist_q <= dist_mem[rd_id];
    end

    assign rd_child_id[gi]   = id_q;
    assign rd_child_dist[gi] = dist_q;
  end

endmodule

// File: rtl/dijkstra_graph_engine.sv
// Dijkstra engine: linear min-scan, per-slot relaxation, parent-chain trace
// into a path buffer that the host reads back in start-to-goal order.
module dijkstra_graph_engine
  import dijkstra_pkg::*;
#(
  parameter int N_NODES    = DEF_N_NODES,
  parameter int MAX_CHILD  = DEF_MAX_CHILD,
  parameter int COORD_W    = DEF_COORD_W,
  parameter int COST_W     = DEF_COST_W,
  parameter int PATH_DEPTH = DEF_PATH_DEPTH,
  localparam int ID_W      = $clog2(N_NODES),
  localparam int PL_W      = $clog2(PATH_DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic [ID_W-1:0]                   load_id,
  input  logic [COORD_W-1:0]                load_x,
  input  logic [COORD_W-1:0]                load_y,
  input  logic [MAX_CHILD-1:0]              load_child_valid,
  input  logic [MAX_CHILD-1:0][ID_W-1:0]    load_child_id,
  input  logic [MAX_CHILD-1:0][COST_W-1:0]  load_child_dist,
  input  logic                              start,
  input  logic [ID_W-1:0]                   start_id,
  input  logic [ID_W-1:0]                   goal_id,
  output logic                              busy,
  output logic                              done,
  output logic                              success,
  output logic                              overflow,
  output logic [COST_W-1:0]                 total_cost,
  output logic [PL_W-1:0]                   path_len,
  input  logic [PL_W-1:0]                   rd_idx,
  output logic [COORD_W-1:0]                rd_x,
  output logic [COORD_W-1:0]                rd_y
);

  localparam int SLOT_W = (MAX_CHILD > 1) ? $clog2(MAX_CHILD) : 1;
  localparam int PB_W   = (PATH_DEPTH > 1) ? $clog2(PATH_DEPTH) : 1;
  localparam int IDX_W  = ID_W + 1;
  localparam logic [COST_W-1:0] INF       = '1;
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_NODES - 1);
  localparam logic [IDX_W-1:0]  ID_LIMIT  = IDX_W'(N_NODES);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MAX_CHILD - 1);
  localparam logic [PL_W-1:0]   PATH_FULL = PL_W'(PATH_DEPTH);

  state_t state_reg, state_next;
  logic [ID_W-1:0]   idx_reg, start_reg, goal_reg, min_id_reg, n_reg;
  logic [COST_W-1:0] min_dist_reg, total_cost_reg;
  logic              found_reg, success_reg, overflow_reg, done_reg;
  logic [SLOT_W-1:0] slot_reg;
  logic [PL_W-1:0]   k_reg, path_len_reg;
  logic [COORD_W-1:0] rd_x_reg, rd_y_reg;

  logic [COST_W-1:0] dist_mem   [N_NODES];
  logic [ID_W-1:0]   parent_mem [N_NODES];
  logic [N_NODES-1:0] visited_reg;
  coord_t            path_mem   [PATH_DEPTH];

  logic [ID_W-1:0]                  tbl_addr;
  coord_t                           tbl_coord;
  logic [MAX_CHILD-1:0]             tbl_child_valid;
  logic [MAX_CHILD-1:0][ID_W-1:0]   tbl_child_id;
  logic [MAX_CHILD-1:0][COST_W-1:0] tbl_child_dist;

  logic              ids_ok, last_idx, take, found_next, route_dead, goal_hit;
  logic              relax_en, trace_full;
  logic [ID_W-1:0]   min_id_next, child_id;
  logic [COST_W-1:0] min_dist_next, child_dist;
  logic [COST_W:0]   relax_sum;
  logic [PB_W-1:0]   rd_addr;

  dijkstra_node_table #(
    .N_NODES(N_NODES), .MAX_CHILD(MAX_CHILD), .COST_W(COST_W), .ID_W(ID_W)
  ) u_table (
    .clk            (clk),
    .wr_en          (load_valid && load_ready),
    .wr_id          (load_id),
    .wr_coord       ('{x: load_x, y: load_y}),
    .wr_child_valid (load_child_valid),
    .wr_child_id    (load_child_id),
    .wr_child_dist  (load_child_dist),
    .rd_id          (tbl_addr),
    .rd_coord       (tbl_coord),
    .rd_child_valid (tbl_child_valid),
    .rd_child_id    (tbl_child_id),
    .rd_child_dist  (tbl_child_dist)
  );

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    ids_ok        = ({1'b0, start_id} < ID_LIMIT) && ({1'b0, goal_id} < ID_LIMIT);
    last_idx      = idx_reg == LAST_ID;
    take          = !visited_reg[idx_reg] && (!found_reg || dist_mem[idx_reg] < min_dist_reg);
    found_next    = found_reg || !visited_reg[idx_reg];
    min_id_next   = take ? idx_reg : min_id_reg;
    min_dist_next = take ? dist_mem[idx_reg] : min_dist_reg;
    route_dead    = !found_next || (min_dist_next == INF);
    goal_hit      = min_id_next == goal_reg;
    child_id      = tbl_child_id[slot_reg];
    child_dist    = tbl_child_dist[slot_reg];
    // Extra carry bit so a saturating sum can never look shorter than INF.
    relax_sum     = {1'b0, min_dist_reg} + {1'b0, child_dist};
    relax_en      = tbl_child_valid[slot_reg] && ({1'b0, child_id} < ID_LIMIT) &&
                    !visited_reg[child_id] && (relax_sum < {1'b0, dist_mem[child_id]}) &&
                    (relax_sum < {1'b0, INF});
    trace_full    = k_reg == PATH_FULL;
    state_next    = state_reg;
    tbl_addr      = min_id_next;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ids_ok ? ST_INIT : ST_FIN;
      ST_INIT:  if (last_idx) state_next = ST_SCAN;
      ST_SCAN: begin
        // Addressing the running minimum lets the table data for u be ready on RELAX entry.
        tbl_addr = min_id_next;
        if (last_idx) state_next = route_dead ? ST_FIN : (goal_hit ? ST_TRACE : ST_RELAX);
      end
      ST_RELAX: begin
        tbl_addr = min_id_reg;
        if (slot_reg == LAST_SLOT) state_next = ST_SCAN;
      end
      ST_TRACE: begin
        tbl_addr = parent_mem[n_reg];
        if (trace_full || n_reg == start_reg) state_next = ST_FIN;
      end
      ST_FIN:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_reg       <= 1'b0;
      success_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
      total_cost_reg <= '0;
      path_len_reg   <= '0;
      idx_reg        <= '0;
      slot_reg       <= '0;
      k_reg          <= '0;
      found_reg      <= 1'b0;
      min_id_reg     <= '0;
      min_dist_reg   <= '0;
      n_reg          <= '0;
      start_reg      <= '0;
      goal_reg       <= '0;
    end else begin
      done_reg <= state_reg == ST_FIN;
      case (state_reg)
        ST_IDLE: if (start) begin
          success_reg    <= 1'b0;
          overflow_reg   <= 1'b0;
          total_cost_reg <= '0;
          path_len_reg   <= '0;
          start_reg      <= start_id;
          goal_reg       <= goal_id;
          idx_reg        <= '0;
        end
        ST_INIT: begin
          idx_reg   <= last_idx ? '0 : idx_reg + 1'b1;
          found_reg <= 1'b0;
        end
        ST_SCAN: begin
          found_reg    <= found_next;
          min_id_reg   <= min_id_next;
          min_dist_reg <= min_dist_next;
          idx_reg      <= last_idx ? '0 : idx_reg + 1'b1;
          slot_reg     <= '0;
          if (last_idx && !route_dead && goal_hit) begin
            total_cost_reg <= min_dist_next;
            n_reg          <= goal_reg;
            k_reg          <= '0;
          end
        end
        ST_RELAX: begin
          slot_reg <= slot_reg + 1'b1;
          if (slot_reg == LAST_SLOT) found_reg <= 1'b0;
        end
        ST_TRACE: begin
          if (trace_full) begin
            success_reg  <= 1'b0;
            overflow_reg <= 1'b1;
            path_len_reg <= '0;
          end else if (n_reg == start_reg) begin
            success_reg  <= 1'b1;
            path_len_reg <= k_reg + 1'b1;
          end else begin
            n_reg <= parent_mem[n_reg];
            k_reg <= k_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Search scratch memories; INIT rebuilds them before every route.
  always_ff @(posedge clk) begin
    case (state_reg)
      ST_INIT: begin
        dist_mem[idx_reg]    <= INF;
        parent_mem[idx_reg]  <= idx_reg;
        visited_reg[idx_reg] <= 1'b0;
        if (last_idx) dist_mem[start_reg] <= '0;
      end
      ST_SCAN:  if (state_next == ST_RELAX) visited_reg[min_id_next] <= 1'b1;
      ST_RELAX: if (relax_en) begin
        dist_mem[child_id]   <= relax_sum[COST_W-1:0];
        parent_mem[child_id] <= min_id_reg;
      end
      ST_TRACE: if (!trace_full) path_mem[PB_W'(k_reg)] <= tbl_coord;
      default: ;
    endcase
  end

  // The buffer holds goal first, so readout index counts back from the end.
  assign rd_addr = PB_W'(path_len_reg - PL_W'(1) - rd_idx);

  always_ff @(posedge clk) begin
    if (reset || !(rd_idx < path_len_reg)) begin
      rd_x_reg <= '0;
      rd_y_reg <= '0;
    end else begin
      rd_x_reg <= path_mem[rd_addr].x;
      rd_y_reg <= path_mem[rd_addr].y;
    end
  end

  assign load_ready = state_reg == ST_IDLE;
  assign busy       = state_reg != ST_IDLE;
  assign done       = done_reg;
  assign success    = success_reg;
  assign overflow   = overflow_reg;
  assign total_cost = total_cost_reg;
  assign path_len   = path_len_reg;
  assign rd_x       = rd_x_reg;
  assign rd_y       = rd_y_reg;

endmodule

// File: tb/tb_dijkstra_graph_engine.sv
// Directed bench for dijkstra_graph_engine on the four-node store graph,
// plus a two-entry path buffer instance for the overflow case.
module tb_dijkstra_graph_engine;

  localparam int ID_W  = 6;
  localparam int PL_W  = 7;
  localparam int PL2_W = 2;
  localparam int MC    = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_valid = 1'b0;
  logic [ID_W-1:0] load_id = '0;
  logic [15:0] load_x = '0, load_y = '0;
  logic [MC-1:0] load_child_valid = '0;
  logic [MC-1:0][ID_W-1:0] load_child_id = '0;
  logic [MC-1:0][15:0] load_child_dist = '0;
  logic start = 1'b0, start2 = 1'b0;
  logic [ID_W-1:0] start_id = '0, goal_id = '0;

  logic load_ready, busy, done, success, overflow;
  logic [15:0] total_cost, rd_x, rd_y;
  logic [PL_W-1:0] path_len;
  logic [PL_W-1:0] rd_idx = '0;

  logic load_ready2, busy2, done2, success2, overflow2;
  logic [15:0] total_cost2, rd_x2, rd_y2;
  logic [PL2_W-1:0] path_len2;
  logic [PL2_W-1:0] rd_idx2 = '0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dijkstra_graph_engine dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_id(load_id),
    .load_x(load_x), .load_y(load_y), .load_child_valid(load_child_valid),
    .load_child_id(load_child_id), .load_child_dist(load_child_dist),
    .start(start), .start_id(start_id), .goal_id(goal_id),
    .busy(busy), .done(done), .success(success), .overflow(overflow),
    .total_cost(total_cost), .path_len(path_len),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y)
  );

  dijkstra_graph_engine #(.PATH_DEPTH(2)) dut_pd2 (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready2), .load_id(load_id),
    .load_x(load_x), .load_y(load_y), .load_child_valid(load_child_valid),
    .load_child_id(load_child_id), .load_child_dist(load_child_dist),
    .start(start2), .start_id(start_id), .goal_id(goal_id),
    .busy(busy2), .done(done2), .success(success2), .overflow(overflow2),
    .total_cost(total_cost2), .path_len(path_len2),
    .rd_idx(rd_idx2), .rd_x(rd_x2), .rd_y(rd_y2)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_node(input int id, input int x, input int y, input int n,
                           input int c0, input int d0, input int c1, input int d1,
                           input int c2, input int d2);
    load_valid = 1'b1;
    load_id = ID_W'(id);
    load_x = 16'(x);
    load_y = 16'(y);
    load_child_valid = '0;
    load_child_id = '0;
    load_child_dist = '0;
    load_child_valid[0] = n > 0;
    load_child_valid[1] = n > 1;
    load_child_valid[2] = n > 2;
    load_child_id[0] = ID_W'(c0);  load_child_dist[0] = 16'(d0);
    load_child_id[1] = ID_W'(c1);  load_child_dist[1] = 16'(d1);
    load_child_id[2] = ID_W'(c2);  load_child_dist[2] = 16'(d2);
    tick();
    load_valid = 1'b0;
    $display("load node %0d (%0d,%0d) children=%0d", id, x, y, n);
  endtask

  // Pulses start on one instance and waits (bounded) for its done pulse.
  // dup_at >= 0 injects a second start (2->2) that many cycles in.
  task automatic run_route(input int s, input int g, input bit pd2, input int dup_at);
    int cyc;
    logic d;
    start_id = ID_W'(s);
    goal_id = ID_W'(g);
    if (pd2) start2 = 1'b1;
    else start = 1'b1;
    tick();
    start = 1'b0;
    start2 = 1'b0;
    check("busy_after_start", pd2 ? busy2 : busy, 1);
    cyc = 1;
    d = pd2 ? done2 : done;
    while (!d && cyc < 2000) begin
      if (cyc == dup_at) begin
        start_id = ID_W'(2);
        goal_id = ID_W'(2);
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      cyc++;
      d = pd2 ? done2 : done;
    end
    check("done_seen", d, 1);
    check("busy_low_at_done", pd2 ? busy2 : busy, 0);
    if (pd2)
      $display("route %0d->%0d (pd2): %0d cycles success=%0d overflow=%0d len=%0d",
               s, g, cyc, success2, overflow2, path_len2);
    else
      $display("route %0d->%0d: %0d cycles success=%0d overflow=%0d cost=%0d len=%0d",
               s, g, cyc, success, overflow, total_cost, path_len);
  endtask

  task automatic read_coord(input int idx, input int ex, input int ey);
    rd_idx = PL_W'(idx);
    tick();
    check($sformatf("rd_x[%0d]", idx), rd_x, ex);
    check($sformatf("rd_y[%0d]", idx), rd_y, ey);
    $display("readout %0d -> (%0d,%0d)", idx, rd_x, rd_y);
  endtask

  initial begin
    int done_count;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_success", success, 0);
    check("rst_overflow", overflow, 0);
    check("rst_cost", total_cost, 0);
    check("rst_len", path_len, 0);
    check("rst_rd_x", rd_x, 0);
    check("rst_rd_y", rd_y, 0);
    check("rst_load_ready", load_ready, 1);

    load_node(0, 10, 10, 2, 1, 4, 2, 2, 0, 0);
    load_node(1, 20, 10, 1, 3, 5, 0, 0, 0, 0);
    load_node(2, 20, 20, 2, 1, 1, 3, 9, 0, 0);
    load_node(3, 30, 30, 0, 0, 0, 0, 0, 0, 0);

    run_route(0, 3, 1'b0, -1);
    check("r03_success", success, 1);
    check("r03_overflow", overflow, 0);
    check("r03_cost", total_cost, 8);
    check("r03_len", path_len, 4);
    tick();
    check("done_one_cycle", done, 0);
    read_coord(0, 10, 10);
    read_coord(1, 20, 20);
    read_coord(2, 20, 10);
    read_coord(3, 30, 30);
    read_coord(4, 0, 0);

    run_route(2, 2, 1'b0, -1);
    check("r22_success", success, 1);
    check("r22_cost", total_cost, 0);
    check("r22_len", path_len, 1);
    read_coord(0, 20, 20);

    run_route(3, 0, 1'b0, -1);
    check("r30_success", success, 0);
    check("r30_len", path_len, 0);
    check("r30_cost", total_cost, 0);
    check("r30_overflow", overflow, 0);

    load_node(0, 10, 10, 3, 1, 4, 2, 2, 3, 'hFFFE);
    run_route(0, 3, 1'b0, -1);
    check("sat_success", success, 1);
    check("sat_cost", total_cost, 8);
    check("sat_len", path_len, 4);

    run_route(0, 3, 1'b1, -1);
    check("pd2_success", success2, 0);
    check("pd2_overflow", overflow2, 1);
    check("pd2_len", path_len2, 0);

    run_route(0, 3, 1'b0, 10);
    check("dup_success", success, 1);
    check("dup_cost", total_cost, 8);
    check("dup_len", path_len, 4);

    // Accept edge is cycle 0: INIT 1..64, SCAN 65..128, RELAX 129..134.
    start_id = ID_W'(0);
    goal_id = ID_W'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (129) tick();
    check("mid_busy_before_reset", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("reset applied mid-RELAX");
    check("mid_rst_busy", busy, 0);
    check("mid_rst_load_ready", load_ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_success", success, 0);
    check("mid_rst_len", path_len, 0);
    check("mid_rst_cost", total_cost, 0);
    check("mid_rst_rd_x", rd_x, 0);
    done_count = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (done) done_count++;
    end
    check("mid_rst_no_done", done_count, 0);

    run_route(0, 3, 1'b0, -1);
    check("rerun_success", success, 1);
    check("rerun_cost", total_cost, 8);
    check("rerun_len", path_len, 4);
    read_coord(1, 20, 20);
    read_coord(2, 20, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dijkstra_graph_engine.md
# dijkstra_graph_engine

Parametrised shortest-path engine for the SmartCart store map, generalising the fixed six-child, struct-input Dijkstra core. The host loads a graph of up to N_NODES nodes into an internal node table, then requests a route by start/goal id. The engine runs Dijkstra with sequential min-scan and relaxation and reports success, total cost and path length. The host reads back the path coordinates in start-to-goal order.

## Interface
- N_NODES, 64: node table depth; ids 0..N_NODES-1; ID_W = $clog2(N_NODES)
- MAX_CHILD, 6: child slots per node
- COORD_W, 16: x/y width
- COST_W, 16: distance/cost width; INF = all ones
- PATH_DEPTH, 64: path buffer entries; PL_W = $clog2(PATH_DEPTH+1)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- load_valid  in  1  write one node record (accepted only when load_ready)
- load_ready  out  1  high in IDLE
- load_id  in  ID_W  node written
- load_x, load_y  in  COORD_W each  node coordinates
- load_child_valid  in  MAX_CHILD  per-slot edge present
- load_child_id  in  MAX_CHILD x ID_W  child ids
- load_child_dist  in  MAX_CHILD x COST_W  edge lengths
- start  in  1  request route; sampled in IDLE only
- start_id, goal_id  in  ID_W  sampled with start
- busy  out  1  search in progress
- done  out  1  one-cycle completion pulse
- success  out  1  route found
- overflow  out  1  route longer than PATH_DEPTH
- total_cost  out  COST_W  cost of found route
- path_len  out  PL_W  nodes in route, start and goal included
- rd_idx  in  PL_W  path readout index, 0 = start
- rd_x, rd_y  out  COORD_W each  coords of node rd_idx

## Operation
- States: IDLE, INIT, SCAN, RELAX, TRACE, FIN.
- IDLE -> INIT on start:
  - Clear success, overflow, total_cost and path_len.
  - Latch start_id and goal_id.
  - If either id is >= N_NODES, go directly to FIN with success = 0.
- INIT: one node per cycle, N_NODES cycles. Set dist = INF, visited = 0, parent = self. On the last cycle set dist[start] = 0.
- SCAN: one node per cycle. Track the unvisited node with minimum dist; ties go to the lowest id. At end of scan:
  - If min dist is INF, or no unvisited node remains: go to FIN with success = 0.
  - If the min node is goal: set total_cost = dist[goal] and go to TRACE.
  - Otherwise mark the node visited and go to RELAX.
- RELAX: one child slot per cycle, MAX_CHILD cycles, then SCAN. For each valid slot c:
  - Compute the sum dist[u] + d at COST_W+1 bits.
  - If sum < dist[c] and sum < INF: set dist[c] = sum and parent[c] = u.
  - Invalid slots, out-of-range ids and already-visited children are skipped.
- TRACE:
  - Start with n = goal. Each cycle, write coord[n] to pathbuf[k], increment k, and set n = parent[n].
  - Stop after writing start: success = 1, path_len = k.
  - If k would exceed PATH_DEPTH: success = 0, overflow = 1, path_len = 0.
- FIN: done = 1 for one cycle, then IDLE.
- Readout: rd_x/rd_y = pathbuf[path_len-1-rd_idx], registered.
  - rd_idx >= path_len returns 0/0.
  - Valid in IDLE only.
- start while busy is ignored. load_valid while busy is ignored.
- Loading the same id twice: the last write wins.
- reset mid-search:
  - Returns to IDLE next cycle.
  - Node table is not cleared; it is RAM and must be reloaded only by choice.
  - All status outputs are cleared.

## Timing
- Reset values:
  - busy = 0, done = 0, success = 0, overflow = 0.
  - total_cost = 0, path_len = 0, rd_x = rd_y = 0.
  - load_ready = 1, state IDLE.
- Node write takes effect at the clock edge where load_valid & load_ready. A start on the following cycle sees the write.
- busy rises the cycle after start is accepted and falls in the cycle done is high.
- success, overflow, total_cost and path_len are valid from the done cycle until the next accepted start.
- Latency from start to done ≤ 1 + N_NODES + V·(N_NODES + MAX_CHILD + 1) + PATH_DEPTH + 1, where V is the number of visited nodes.
- Invalid-id start gives done 2 cycles after start.
- Readout latency is 1 cycle from rd_idx.

## Structure
- dijkstra_pkg holds:
  - coord_t (COORD_W = 16 packed x/y)
  - state enum
  - default parameter constants
  - INF helper function
- Sub-module dijkstra_node_table holds the node records:
  - Write port from the load interface.
  - Read port A for coords and children of u during RELAX/TRACE.
  - dist, parent and visited live in the engine.

## Test plan
- Shared graph, with (x,y) per node:
  - Nodes: 0 (10,10), 1 (20,10), 2 (20,20), 3 (30,30).
  - Edges: 0->1 d4, 0->2 d2, 2->1 d1, 1->3 d5, 2->3 d9.
- Route 0->3 on the shared graph -> success = 1, total_cost = 8, path_len = 4, readout (10,10),(20,20),(20,10),(30,30).
- start 2, goal 2 -> success = 1, cost = 0, path_len = 1, rd 0 = (20,20).
- start 3, goal 0 (node 3 has no edges) -> done with success = 0, path_len = 0, total_cost = 0.
- Add edge 0->3 d0xFFFE, then route 0->3 -> still cost 8; saturation gives no false relax.
- PATH_DEPTH = 2 instance, route 0->3 -> success = 0, overflow = 1.
- Robustness run:
  - Second start while busy is ignored; the first result is unchanged.
  - reset mid-RELAX -> IDLE, outputs 0.
  - A rerun gives the same result without reloading.
